gpu_cmd_queue: RTL

//  Downstream stage of the GPU AXI4 slave. It takes 32-bit command words from the slave's write datapath
//  and buffers them in a FIFO. It decodes each word into a draw command for the pixel renderer.

---
 rtl/gpu_cmd_pkg.sv | 44 ++++
 rtl/gpu_sync_fifo.sv | 50 +++++
 rtl/gpu_cmd_queue.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/gpu_cmd_pkg.sv
// Shared types for the GPU command queue: opcode enum, command word layout,
// queue FSM states and small opcode-class helpers.
package gpu_cmd_pkg;

  localparam int OP_W  = 3;
  localparam int SPR_W = 8;
  localparam int Y_W   = 10;
  localparam int X_W   = 11;

  typedef enum logic [OP_W-1:0] {
    OP_NOP         = 3'd0,
    OP_DRAW_SPRITE = 3'd1,
    OP_FILL_TILE   = 3'd2,
    OP_CLEAR       = 3'd3,
    OP_SET_PALETTE = 3'd4,
    OP_RSVD5       = 3'd5,
    OP_RSVD6       = 3'd6,
    OP_END_FRAME   = 3'd7
  } gpu_op_e;

  typedef struct packed {
    gpu_op_e            op;
    logic [SPR_W-1:0]   sprite;
    logic [Y_W-1:0]     y;
    logic [X_W-1:0]     x;
  } gpu_cmd_t;

  typedef enum logic {
    ST_RUN,
    ST_WAIT_VSYNC
  } q_state_e;

  // Opcodes that reach the renderer.
  function automatic logic op_is_forwarded(gpu_op_e op);
    return (op == OP_DRAW_SPRITE) || (op == OP_FILL_TILE) ||
           (op == OP_CLEAR) || (op == OP_SET_PALETTE);
  endfunction

  // Opcodes that are dropped and flagged as an error.
  function automatic logic op_is_reserved(gpu_op_e op);
    return (op == OP_RSVD5) || (op == OP_RSVD6);
  endfunction

endpackage

// File: rtl/gpu_sync_fifo.sv
// Single-clock FIFO with combinational head read, full/empty flags and a
// fill level. Pointers wrap modulo DEPTH (DEPTH must be a power of 2).
module gpu_sync_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  // Storage write; contents are not cleared by reset, only the pointers are.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointer and level bookkeeping; simultaneous push/pop leaves level unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/gpu_cmd_queue.sv
// GPU command queue: buffers 32-bit command words, decodes them, and feeds
// the renderer one command per clock, pausing after END_FRAME until vsync.
// Optional statistics counters are enabled with the GPU_CMD_STATS_EN macro.
module gpu_cmd_queue
  import gpu_cmd_pkg::*;
#(
  parameter  int DEPTH   = 16,
  localparam int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [31:0]        wr_data,
  input  logic               vsync_pulse,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [OP_W-1:0]    cmd_op,
  output logic [SPR_W-1:0]   cmd_sprite,
  output logic [Y_W-1:0]     cmd_y,
  output logic [X_W-1:0]     cmd_x,
  output logic [LEVEL_W-1:0] fifo_level,
  output logic               err_sticky,
  input  logic               err_clr
`ifdef GPU_CMD_STATS_EN
  ,
  output logic [15:0]        frame_cnt,
  output logic [31:0]        cmd_cnt
`endif
);

  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic [31:0] fifo_rdata;
  gpu_cmd_t    head;
  gpu_cmd_t    cmd_q;
  q_state_e    state;
  q_state_e    state_next;
  logic        load_en;
  logic        fwd;
  logic        set_err;
  logic        frame_done;

  // No bypass: a pop in the same cycle never frees a slot for a push.
  assign wr_ready = !reset && !fifo_full;
  assign push     = wr_valid && wr_ready;
  assign head     = gpu_cmd_t'(fifo_rdata);
  assign load_en  = !cmd_valid || cmd_ready;

  gpu_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (wr_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Head decode and next state: forwarded ops wait for the output register,
  // everything else is consumed immediately while running.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    fwd        = 1'b0;
    set_err    = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_RUN: begin
        if (!fifo_empty) begin
          if (op_is_forwarded(head.op)) begin
            fwd = load_en;
            pop = load_en;
          end else begin
            pop     = 1'b1;
            set_err = op_is_reserved(head.op);
            if (head.op == OP_END_FRAME) state_next = ST_WAIT_VSYNC;
          end
        end
      end
      ST_WAIT_VSYNC: begin
        if (vsync_pulse) begin
          state_next = ST_RUN;
          frame_done = 1'b1;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  // Output register: holds while stalled, drops valid after a handshake
  // unless a new command is loaded in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_valid <= 1'b0;
      cmd_q     <= '0;
    end else if (load_en) begin
      cmd_valid <= fwd;
      if (fwd) cmd_q <= head;
    end
  end

  assign cmd_op     = cmd_q.op;
  assign cmd_sprite = cmd_q.sprite;
  assign cmd_y      = cmd_q.y;
  assign cmd_x      = cmd_q.x;

  // Sticky reserved-opcode flag; clear wins over a simultaneous set.
  always_ff @(posedge clock) begin
    if (reset)        err_sticky <= 1'b0;
    else if (err_clr) err_sticky <= 1'b0;
    else if (set_err) err_sticky <= 1'b1;
  end

`ifdef GPU_CMD_STATS_EN
  // Frame and delivered-command counters, free-running with natural wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt <= '0;
      cmd_cnt   <= '0;
    end else begin
      if (frame_done)             frame_cnt <= frame_cnt + 16'd1;
      if (cmd_valid && cmd_ready) cmd_cnt   <= cmd_cnt + 32'd1;
    end
  end
`endif

endmodule
